// File: rtl/user_mgr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// user_mgr_arbiter_pkg
// Shared types and constants for the user-domain manager arbiter.
//   - NumUserMgr / UserMgrMaxTrans : instance constants used by the user domain
//   - mgr_obi_req_t / mgr_obi_rsp_t: default OBI request/response structs
//   - idx_width()                  : width of a manager index (never below 1)
// -----------------------------------------------------------------------------
package user_mgr_arbiter_pkg;

    // Number of upstream managers and downstream outstanding depth used by
    // the user domain when it instantiates the arbiter.
    localparam int unsigned NumUserMgr      = 2;
    localparam int unsigned UserMgrMaxTrans = 2;

    localparam int unsigned ObiAddrW = 32;
    localparam int unsigned ObiDataW = 32;
    localparam int unsigned ObiIdW   = 1;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [ObiDataW/8-1:0] be;
        logic [ObiAddrW-1:0]   addr;
        logic [ObiDataW-1:0]   wdata;
        logic [ObiIdW-1:0]     aid;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [ObiDataW-1:0] rdata;
        logic [ObiIdW-1:0]   rid;
        logic                err;
    } mgr_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        mgr_obi_r_t r;
    } mgr_obi_rsp_t;

    // A single manager still needs a 1-bit index so the FIFO has a data lane.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_mgr_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// user_mgr_arbiter_fifo
// In-order index FIFO (registered output, no fall-through) remembering which
// manager owns each outstanding downstream transaction.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write an entry; accepted when not full or when popping
//   pop_i         : remove the head entry; ignored when empty
//   data_o        : current head entry
//   full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
module user_mgr_arbiter_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned DataW = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DataW-1:0] data_i,
    input  logic             pop_i,
    output logic [DataW-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned UsageW = $clog2(Depth + 1);

    logic [DataW-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [UsageW-1:0] usage_q;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (usage_q == UsageW'(Depth));
    assign empty_o = (usage_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr_q <= ptr_incr(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_q <= ptr_incr(wr_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   usage_q <= usage_q + UsageW'(1);
                2'b01:   usage_q <= usage_q - UsageW'(1);
                default: usage_q <= usage_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and usage count
    // define validity, so the array maps to plain flops/RAM without reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/user_mgr_arbiter.sv
// -----------------------------------------------------------------------------
// user_mgr_arbiter
// Round-robin arbiter funnelling NumMgr upstream OBI managers onto a single
// downstream OBI manager port. A winner is locked until granted, and an index
// FIFO routes each in-order response back to the manager that issued it.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   mgr_req_i      : upstream requests, one per manager
//   mgr_rsp_o      : upstream responses (gnt/rvalid steered, r broadcast)
//   out_req_o      : downstream request (selected manager's request)
//   out_rsp_i      : downstream response
//   busy_o         : at least one transaction outstanding
//   spurious_rsp_o : sticky; an rvalid arrived with nothing outstanding
// -----------------------------------------------------------------------------
module user_mgr_arbiter
    import user_mgr_arbiter_pkg::*;
#(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned MaxTrans  = 2,
    parameter type         obi_req_t = mgr_obi_req_t,
    parameter type         obi_rsp_t = mgr_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t mgr_req_i [NumMgr],
    output obi_rsp_t mgr_rsp_o [NumMgr],
    output obi_req_t out_req_o,
    input  obi_rsp_t out_rsp_i,
    output logic     busy_o,
    output logic     spurious_rsp_o
);

    localparam int unsigned IdxW = idx_width(NumMgr);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    typedef logic [IdxW-1:0] idx_t;

    idx_t            rr_ptr_q;
    idx_t            lock_idx_q;
    logic            lock_q;
    logic [CntW-1:0] count_q;
    logic            spurious_q;

    idx_t rr_winner;
    logic rr_found;
    idx_t winner;
    logic any_req;
    idx_t head_idx;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic out_valid;

    // Manager index reached by stepping 'off' places from 'base', modulo NumMgr.
    function automatic idx_t wrap_idx(input int unsigned base, input int unsigned off);
        return idx_t'((base + off) % NumMgr);
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin search: first requester at or above rr_ptr, wrapping.
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int unsigned k = 0; k < NumMgr; k++) begin
            if (!rr_found && mgr_req_i[wrap_idx(32'(rr_ptr_q), k)].req) begin
                rr_found  = 1'b1;
                rr_winner = wrap_idx(32'(rr_ptr_q), k);
            end
        end
    end

    // A request that was offered but not granted keeps its manager selected,
    // so the downstream port never sees the request change under it.
    always_comb begin
        winner  = rr_winner;
        any_req = rr_found;
        if (lock_q) begin
            winner  = lock_idx_q;
            any_req = mgr_req_i[lock_idx_q].req;
        end
    end

    // -------------------------------------------------------------------------
    // Downstream request and handshake qualification
    // -------------------------------------------------------------------------
    assign pop       = out_rsp_i.rvalid & ~fifo_empty;
    // Offer a request only if the index can be stored: room in the FIFO or a
    // response freeing the head this cycle. Reset forces the port quiet.
    assign out_valid = rst_ni & any_req & (~fifo_full | pop);
    assign push      = out_valid & out_rsp_i.gnt;

    always_comb begin
        out_req_o     = mgr_req_i[winner];
        out_req_o.req = out_valid;
    end

    // -------------------------------------------------------------------------
    // Upstream responses: gnt to the winner, rvalid to the FIFO head,
    // read payload broadcast so only the valid strobes need steering.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            mgr_rsp_o[i]        = '0;
            mgr_rsp_o[i].r      = out_rsp_i.r;
            mgr_rsp_o[i].gnt    = push & (winner == idx_t'(i));
            mgr_rsp_o[i].rvalid = pop & (head_idx == idx_t'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration state: pointer advances past the winner on each handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (push) begin
            rr_ptr_q <= wrap_idx(32'(winner), 1);
            lock_q   <= 1'b0;
        end else if (out_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end
    end

    // Outstanding count cannot wrap: pushes are gated by FIFO-full and pops
    // only happen when the FIFO holds an entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Responses with no owner are dropped; the flag records that it happened.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spurious_q <= 1'b0;
        end else if (out_rsp_i.rvalid && fifo_empty) begin
            spurious_q <= 1'b1;
        end
    end

    assign busy_o         = (count_q != '0);
    assign spurious_rsp_o = spurious_q;

    // -------------------------------------------------------------------------
    // Owner index FIFO
    // -------------------------------------------------------------------------
    user_mgr_arbiter_fifo #(
        .Depth (MaxTrans),
        .DataW (IdxW)
    ) i_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_user_mgr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_user_mgr_arbiter
// Self-checking bench for user_mgr_arbiter (2 managers, 2 outstanding).
// Inputs change on the falling edge; outputs are sampled 1 ns later. A
// behavioural model (owner queue, round-robin pointer, held manager) predicts
// the combinational outputs each cycle and is advanced on the rising edge.
// -----------------------------------------------------------------------------
module tb_user_mgr_arbiter;
    import user_mgr_arbiter_pkg::*;

    localparam int NUM = 2;
    localparam int MT  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    mgr_obi_req_t mgr_req [NUM];
    mgr_obi_rsp_t mgr_rsp [NUM];
    mgr_obi_req_t out_req;
    mgr_obi_rsp_t out_rsp;
    logic         busy;
    logic         spur;

    logic [NUM-1:0] act_gnt;
    logic [NUM-1:0] act_rv;

    int checks   = 0;
    int failures = 0;

    // Model state
    int       m_rr;
    int       m_held;
    int       m_q[$];
    bit       m_spur;
    // Model predictions for the current cycle
    bit             e_req;
    int             e_win;
    bit             e_pop;
    logic [NUM-1:0] e_gnt;
    logic [NUM-1:0] e_rv;
    bit             e_busy;

    always #5 clk = ~clk;

    user_mgr_arbiter #(
        .NumMgr   (NUM),
        .MaxTrans (MT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .mgr_req_i      (mgr_req),
        .mgr_rsp_o      (mgr_rsp),
        .out_req_o      (out_req),
        .out_rsp_i      (out_rsp),
        .busy_o         (busy),
        .spurious_rsp_o (spur)
    );

    always_comb begin
        act_gnt = '0;
        act_rv  = '0;
        for (int i = 0; i < NUM; i++) begin
            act_gnt[i] = mgr_rsp[i].gnt;
            act_rv[i]  = mgr_rsp[i].rvalid;
        end
    end

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i * 32'h100);
    endfunction

    task automatic set_inputs(input logic [NUM-1:0] rq, input logic g,
                              input logic rv, input logic [31:0] rd);
        for (int i = 0; i < NUM; i++) begin
            mgr_req[i]       = '0;
            mgr_req[i].req   = rq[i];
            mgr_req[i].addr  = addr_of(i);
            mgr_req[i].wdata = 32'hCAFE_0000 + 32'(i);
            mgr_req[i].be    = 4'hF;
        end
        out_rsp         = '0;
        out_rsp.gnt     = g;
        out_rsp.rvalid  = rv;
        out_rsp.r.rdata = rd;
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_held = -1;
        m_q.delete();
        m_spur = 1'b0;
    endtask

    task automatic model_eval();
        int  w;
        bit  full;
        w = -1;
        if (m_held >= 0) begin
            if (mgr_req[m_held].req) w = m_held;
        end else begin
            for (int k = 0; k < NUM; k++) begin
                int c;
                c = (m_rr + k) % NUM;
                if (w < 0 && mgr_req[c].req) w = c;
            end
        end
        full   = (m_q.size() == MT);
        e_pop  = out_rsp.rvalid && (m_q.size() > 0);
        e_win  = w;
        e_req  = rst_n && (w >= 0) && (!full || e_pop);
        e_gnt  = '0;
        e_rv   = '0;
        if (e_req && out_rsp.gnt) e_gnt[w] = 1'b1;
        if (e_pop) e_rv[m_q[0]] = 1'b1;
        e_busy = (m_q.size() > 0);
    endtask

    task automatic model_commit();
        if (out_rsp.rvalid && m_q.size() == 0) m_spur = 1'b1;
        if (e_pop) void'(m_q.pop_front());
        if (e_req && out_rsp.gnt) begin
            m_q.push_back(e_win);
            m_rr   = (e_win + 1) % NUM;
            m_held = -1;
        end else if (e_req) begin
            m_held = e_win;
        end
    endtask

    // Drive one cycle's inputs (at a falling edge) and let outputs settle.
    task automatic apply(input logic [NUM-1:0] rq, input logic g,
                         input logic rv, input logic [31:0] rd);
        set_inputs(rq, g, rv, rd);
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_inputs('0, 1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_inputs(2'b11, 1'b1, 1'b1, 32'h1234_5678);
        #1;
        checks++; if (out_req.req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", out_req.req); end
        checks++; if (act_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", act_gnt); end
        checks++; if (act_rv !== 2'b00) begin failures++; $display("FAIL reset_rvalid: got %b want 00", act_rv); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (spur !== 1'b0) begin failures++; $display("FAIL reset_spur: got %b want 0", spur); end
        model_reset();
        set_inputs('0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            apply('0, 1'($urandom_range(0, 1)), 1'b0, $urandom);
            checks++; if (out_req.req !== 1'b0) begin failures++; $display("FAIL idle_req c%0d: got %b want 0", c, out_req.req); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy c%0d: got %b want 0", c, busy); end
            checks++; if (act_gnt !== 2'b00) begin failures++; $display("FAIL idle_gnt c%0d: got %b want 00", c, act_gnt); end
            tick();
        end
    endtask

    task automatic test_contention();
        logic [NUM-1:0] want_gnt;
        logic [NUM-1:0] want_rv;
        logic [31:0]    rd;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            rd = 32'hC0DE_0000 + 32'(c);
            apply(2'b11, 1'b1, c > 0, rd);
            want_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
            want_rv  = (c == 0) ? 2'b00 : (((c - 1) % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (act_gnt !== want_gnt) begin failures++; $display("FAIL contention_gnt c%0d: got %b want %b", c, act_gnt, want_gnt); end
            checks++; if (out_req.addr !== addr_of(c % 2)) begin failures++; $display("FAIL contention_addr c%0d: got %h want %h", c, out_req.addr, addr_of(c % 2)); end
            checks++; if (act_rv !== want_rv) begin failures++; $display("FAIL contention_rvalid c%0d: got %b want %b", c, act_rv, want_rv); end
            if (c > 0) begin
                checks++; if (mgr_rsp[(c - 1) % 2].r.rdata !== rd) begin failures++; $display("FAIL contention_rdata c%0d: got %h want %h", c, mgr_rsp[(c - 1) % 2].r.rdata, rd); end
            end
            tick();
        end
    endtask

    task automatic test_lock();
        logic [NUM-1:0] rq   [5] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01};
        logic           g    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [NUM-1:0] wgnt [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
        int             wmgr [5] = '{1, 1, 1, 1, 0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            apply(rq[c], g[c], 1'b0, 32'h0);
            checks++; if (out_req.req !== 1'b1) begin failures++; $display("FAIL lock_req c%0d: got %b want 1", c, out_req.req); end
            checks++; if (out_req.addr !== addr_of(wmgr[c])) begin failures++; $display("FAIL lock_addr c%0d: got %h want %h", c, out_req.addr, addr_of(wmgr[c])); end
            checks++; if (act_gnt !== wgnt[c]) begin failures++; $display("FAIL lock_gnt c%0d: got %b want %b", c, act_gnt, wgnt[c]); end
            tick();
        end
    endtask

    task automatic test_full_backpressure();
        logic [NUM-1:0] rq    [8] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        logic           rv    [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic           wreq  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [NUM-1:0] wgnt  [8] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [NUM-1:0] wrv   [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
        logic           wbusy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(rq[c], 1'b1, rv[c], 32'hF00D_0000 + 32'(c));
            checks++; if (out_req.req !== wreq[c]) begin failures++; $display("FAIL full_req c%0d: got %b want %b", c, out_req.req, wreq[c]); end
            checks++; if (act_gnt !== wgnt[c]) begin failures++; $display("FAIL full_gnt c%0d: got %b want %b", c, act_gnt, wgnt[c]); end
            checks++; if (act_rv !== wrv[c]) begin failures++; $display("FAIL full_rvalid c%0d: got %b want %b", c, act_rv, wrv[c]); end
            checks++; if (busy !== wbusy[c]) begin failures++; $display("FAIL full_busy c%0d: got %b want %b", c, busy, wbusy[c]); end
            tick();
        end
    endtask

    task automatic test_spurious();
        do_reset();
        apply('0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checks++; if (act_rv !== 2'b00) begin failures++; $display("FAIL spurious_rvalid: got %b want 00", act_rv); end
        tick();
        for (int c = 0; c < 4; c++) begin
            apply('0, 1'b0, 1'b0, 32'h0);
            checks++; if (spur !== 1'b1) begin failures++; $display("FAIL spurious_sticky c%0d: got %b want 1", c, spur); end
            tick();
        end
    endtask

    // Runs straight after test_spurious so the sticky flag is set on entry.
    task automatic test_reset_mid();
        apply(2'b10, 1'b1, 1'b0, 32'h0);
        tick();
        apply(2'b01, 1'b1, 1'b0, 32'h0);
        tick();
        apply('0, 1'b0, 1'b0, 32'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        set_inputs(2'b11, 1'b1, 1'b0, 32'h0);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (spur !== 1'b0) begin failures++; $display("FAIL midrst_spur: got %b want 0", spur); end
        checks++; if (out_req.req !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b want 0", out_req.req); end
        checks++; if (act_gnt !== 2'b00) begin failures++; $display("FAIL midrst_gnt: got %b want 00", act_gnt); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // Response to a transaction lost by the reset
        apply('0, 1'b0, 1'b1, 32'h5555_AAAA);
        checks++; if (act_rv !== 2'b00) begin failures++; $display("FAIL midrst_stale_rvalid: got %b want 00", act_rv); end
        tick();
        apply(2'b11, 1'b1, 1'b0, 32'h0);
        checks++; if (act_gnt !== 2'b01) begin failures++; $display("FAIL midrst_first_gnt: got %b want 01", act_gnt); end
        checks++; if (spur !== 1'b1) begin failures++; $display("FAIL midrst_stale_spur: got %b want 1", spur); end
        tick();
        apply(2'b11, 1'b1, 1'b0, 32'h0);
        checks++; if (act_gnt !== 2'b10) begin failures++; $display("FAIL midrst_second_gnt: got %b want 10", act_gnt); end
        tick();
    endtask

    task automatic test_random();
        logic [NUM-1:0] rq;
        logic [31:0]    rd;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rq = NUM'($urandom);
            if (m_held >= 0) rq[m_held] = 1'b1;   // managers hold req until gnt
            rd = $urandom;
            apply(rq, ($urandom % 4) != 0, ($urandom % 3) == 0, rd);
            checks++; if (out_req.req !== e_req) begin failures++; $display("FAIL rand_req c%0d: got %b want %b", c, out_req.req, e_req); end
            if (e_req) begin
                checks++; if (out_req.addr !== addr_of(e_win)) begin failures++; $display("FAIL rand_addr c%0d: got %h want %h", c, out_req.addr, addr_of(e_win)); end
            end
            checks++; if (act_gnt !== e_gnt) begin failures++; $display("FAIL rand_gnt c%0d: got %b want %b", c, act_gnt, e_gnt); end
            checks++; if (act_rv !== e_rv) begin failures++; $display("FAIL rand_rvalid c%0d: got %b want %b", c, act_rv, e_rv); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, e_busy); end
            checks++; if (spur !== m_spur) begin failures++; $display("FAIL rand_spur c%0d: got %b want %b", c, spur, m_spur); end
            for (int i = 0; i < NUM; i++) begin
                checks++; if (mgr_rsp[i].r.rdata !== rd) begin failures++; $display("FAIL rand_rdata c%0d m%0d: got %h want %h", c, i, mgr_rsp[i].r.rdata, rd); end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        set_inputs('0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_idle();
        test_contention();
        test_lock();
        test_full_backpressure();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/user_mgr_arbiter.md
USER_MGR_ARBITER -- requirements
Module: user_mgr_arbiter

Interface
REQ-001 Parameter NumMgr, default 2: number of upstream OBI managers sharing the user manager port; legal range 1..8.
REQ-002 Parameter MaxTrans, default 2: maximum outstanding transactions on the downstream port; legal range 1..8.
REQ-003 Parameter obi_req_t, default mgr_obi_req_t: OBI request struct type.
REQ-004 Parameter obi_rsp_t, default mgr_obi_rsp_t: OBI response struct type.
REQ-005 Port clk_i, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-006 Port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port mgr_req_i, input, NumMgr x obi_req_t: upstream requests.
REQ-008 Port mgr_rsp_o, output, NumMgr x obi_rsp_t: upstream responses.
REQ-009 Port out_req_o, output, obi_req_t: downstream request to the Croc manager port.
REQ-010 Port out_rsp_i, input, obi_rsp_t: downstream response.
REQ-011 Port busy_o, output, 1 bit: high while the outstanding count is greater than 0.
REQ-012 Port spurious_rsp_o, output, 1 bit: sticky flag; set by an out_rsp_i.rvalid arriving while nothing is outstanding.

Function
REQ-013 Round-robin arbitration: when unlocked, the winner SHALL be the first index i with mgr_req_i[i].req=1, searching from rr_ptr upward and wrapping modulo NumMgr.
REQ-014 out_req_o SHALL be mgr_req_i[winner], with .req forced to 0 when no manager requests or the index FIFO is full and no pop occurs in the same cycle.
REQ-015 Lock: once out_req_o.req=1 without out_rsp_i.gnt, the arbiter SHALL hold the winner in a register until gnt, whatever other managers request.
REQ-016 mgr_rsp_o[winner].gnt SHALL equal out_rsp_i.gnt while out_req_o.req=1; gnt to every other manager SHALL be 0; grant adds zero cycles (combinational).
REQ-017 On each handshake (req and gnt), rr_ptr SHALL update to (winner+1) mod NumMgr, the lock SHALL clear, and the winner index SHALL be pushed into the index FIFO.
REQ-018 Index FIFO: depth MaxTrans, in order, width max(1, clog2(NumMgr)).
REQ-019 The FIFO SHALL pop on out_rsp_i.rvalid when it is non-empty.
REQ-020 mgr_rsp_o[head].rvalid SHALL equal out_rsp_i.rvalid, adding zero cycles; r.rdata, r.rid and r.err SHALL be broadcast to all managers; rvalid to non-head managers SHALL be 0.
REQ-021 Simultaneous push and pop while the FIFO is full SHALL be accepted, with the count unchanged.
REQ-022 out_rsp_i.rvalid while the FIFO is empty SHALL be dropped (no upstream rvalid) and SHALL set spurious_rsp_o, which clears only on reset.
REQ-023 Outstanding counter: width clog2(MaxTrans+1); +1 on push, -1 on pop, unchanged on both; never wraps.
REQ-024 NumMgr=1: the block SHALL still apply the FIFO-full gating and spurious detection.

Reset
REQ-025 Asserting rst_ni low, at any time including mid-transaction, SHALL immediately set: rr_ptr=0, lock cleared, FIFO empty, count=0, busy_o=0, spurious_rsp_o=0.
REQ-026 During reset, out_req_o.req=0 and all upstream gnt/rvalid=0; responses to transactions in flight at reset are treated as spurious afterwards.

Structure
REQ-027 NumUserMgr and UserMgrMaxTrans constants SHALL live in user_pkg; user_domain SHALL instantiate the block with these constants.
REQ-028 The index FIFO SHALL be one sub-module, common_cells fifo_v3 with FallThrough=0; the arbitration logic stays in user_mgr_arbiter.

Verification
REQ-029 Contention: mgr 0 and mgr 1 request continuously, gnt always 1 -> grants alternate 0,1,0,1; each manager gets rvalid matching its own rdata.
REQ-030 Lock: mgr 1 requests, gnt held 0 for 3 cycles, mgr 0 requests in cycle 2 -> out_req_o keeps mgr 1 address until gnt; mgr 0 is granted next.
REQ-031 Full back-pressure: MaxTrans=2, two grants, no rvalid -> out_req_o.req=0 and busy_o=1; rvalid in the same cycle as the third request -> third grant accepted, count stays 2.
REQ-032 Spurious response: rvalid with nothing outstanding, rdata=32'hDEADBEEF -> no upstream rvalid; spurious_rsp_o=1 until reset.
REQ-033 Reset mid-operation: rst_ni low with 2 outstanding -> count=0, busy_o=0, rr_ptr=0; the next request pair grants mgr 0 first.
REQ-034 Idle: no requests for 10 cycles -> out_req_o.req=0, busy_o=0, all upstream gnt=0.
